pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, address width (reserved; no address ports; kept for uniform instantiation).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 256, wait-state cycles before bus_timeout pulses; legal range 2..65535.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req  in  1  instruction fetch outstanding this cycle.
REQ-006 SHALL have port if_ack  in  1  instruction bus returns fetch data this cycle.
REQ-007 SHALL have port mem_req  in  1  MEM stage holds a load or store (EX/MEM MemRead_out|MemWrite_out).
REQ-008 SHALL have port mem_ack  in  1  data bus completes the MEM access this cycle.
REQ-009 SHALL have port ex_branch_taken  in  1  EX resolves a taken branch or jump.
REQ-010 SHALL have port idex_memread  in  1  instruction in ID/EX is a load.
REQ-011 SHALL have port idex_rd_addr  in  5  load destination register.
REQ-012 SHALL have ports id_rs1_addr, id_rs2_addr  in  5 each  sources of the instruction in ID.
REQ-013 SHALL have port pc_stall  out  1  hold PC.
REQ-014 SHALL have ports fs_ifid, fs_idex, fs_exmem, fs_memwb  out  2 each  flush_and_stall per pipeline register: bit1 flush, bit0 stall.
REQ-015 SHALL have port bus_timeout  out  1  one-cycle pulse on wait timeout.
REQ-016 SHALL have port stall_count  out  32  cycles with pc_stall=1.

Function
REQ-017 SHALL run FSM states RUN, MEM_WAIT, IF_WAIT; control outputs are combinational from state and inputs (zero-cycle latency).
REQ-018 SHALL, whenever mem_req=1 and mem_ack=0: pc_stall=1; fs_ifid, fs_idex, fs_exmem=01; fs_memwb=10; next state MEM_WAIT; this has highest priority.
REQ-019 SHALL leave MEM_WAIT to RUN on the cycle mem_ack=1, in which the MEM-wait outputs are not applied.
REQ-020 SHALL, on ex_branch_taken=1 with no MEM wait: fs_ifid=10, fs_idex=10, pc_stall=0, other fs=00.
REQ-021 SHALL, on load-use (idex_memread=1, idex_rd_addr!=0, idex_rd_addr equals id_rs1_addr or id_rs2_addr), no MEM wait, no branch: pc_stall=1, fs_ifid=01, fs_idex=10, others 00; one cycle per hazard.
REQ-022 SHALL, on if_req=1 and if_ack=0 with no higher-priority event: pc_stall=1, fs_ifid=10, others 00; next state IF_WAIT; leave to RUN on if_ack=1.
REQ-023 SHALL set redirect_pending when ex_branch_taken=1 while in IF_WAIT; on the subsequent if_ack cycle assert fs_ifid=10 (discard stale fetch) and clear redirect_pending.
REQ-024 SHALL output all fs=00, pc_stall=0 when no event is active.
REQ-025 SHALL apply priority MEM wait > branch > load-use > IF wait; lower-priority events in the same cycle are ignored (re-evaluated next cycle from held state).
REQ-026 SHALL count consecutive cycles in MEM_WAIT or IF_WAIT in a 16-bit counter cleared on state entry and on ack; pulse bus_timeout for exactly one cycle when count reaches TIMEOUT_CYCLES-1; counter saturates, no further pulses until cleared; waiting continues.
REQ-027 SHALL increment stall_count each cycle pc_stall=1, wrapping 0xFFFF_FFFF to 0.
REQ-028 SHALL treat mem_ack or if_ack without a matching req as no-op.

Reset
REQ-029 SHALL on reset_n=0, immediately and regardless of clk: state RUN, redirect_pending 0, wait counter 0, stall_count 0, bus_timeout 0.
REQ-030 SHALL drive all fs=10 and pc_stall=1 while reset_n=0, regardless of other inputs.
REQ-031 SHALL abandon any wait state on mid-operation reset; first post-reset cycle evaluates from RUN.

Structure
REQ-032 SHALL place state enum and constants FS_NONE=2'b00, FS_STALL=2'b01, FS_FLUSH=2'b10 in shared package pipeline_ctrl_pkg.
REQ-033 SHALL implement the load-use comparison as combinational sub-module load_use_detect.

Verification
REQ-034 Load-use: idex_memread=1, idex_rd_addr=5, id_rs2_addr=5 -> one cycle pc_stall=1, fs_ifid=01, fs_idex=10; with idex_rd_addr=0 -> no stall.
REQ-035 MEM wait: mem_req=1, mem_ack low 3 cycles then high -> 3 cycles fs_exmem=01, fs_memwb=10; ack cycle all 00; stall_count=3.
REQ-036 Priority: mem wait + ex_branch_taken same cycle -> MEM-wait outputs only; branch alone -> fs_ifid=fs_idex=10, pc_stall=0.
REQ-037 Redirect: IF_WAIT, branch taken, if_ack 2 cycles later -> fs_ifid=10 on ack cycle, redirect_pending cleared.
REQ-038 Timeout: TIMEOUT_CYCLES=4, mem_ack held low 10 cycles -> single bus_timeout pulse on 4th wait cycle, stall held throughout.
REQ-039 Reset mid-MEM_WAIT: reset_n low asynchronously -> all fs=10, pc_stall=1 immediately; after release state RUN, stall_count=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
//   state_e : controller FSM states
//   FS_*    : flush_and_stall encodings per pipeline register (bit1 flush, bit0 stall)
//   ctrl_t  : bundle of the combinational control outputs
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_IF_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] FS_NONE  = 2'b00;
  localparam logic [1:0] FS_STALL = 2'b01;
  localparam logic [1:0] FS_FLUSH = 2'b10;

  typedef struct packed {
    logic       pc_stall;
    logic [1:0] ifid;
    logic [1:0] idex;
    logic [1:0] exmem;
    logic [1:0] memwb;
  } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: the load in ID/EX writes a register that the
// instruction in ID reads. x0 is never a real dependency.
//   i_idex_memread : ID/EX holds a load
//   i_idex_rd_addr : load destination
//   i_id_rs1_addr  : ID source 1
//   i_id_rs2_addr  : ID source 2
//   o_hazard       : stall ID one cycle, bubble into EX
module load_use_detect (
  input  logic       i_idex_memread,
  input  logic [4:0] i_idex_rd_addr,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  output logic       o_hazard
);

  logic w_rd_nz;
  logic w_match;

  assign w_rd_nz  = (i_idex_rd_addr != 5'd0);
  assign w_match  = (i_idex_rd_addr == i_id_rs1_addr) || (i_idex_rd_addr == i_id_rs2_addr);
  assign o_hazard = i_idex_memread && w_rd_nz && w_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: turns bus wait states, taken branches and load-use
// hazards into PC stall and per-register flush/stall controls, with a bus
// wait-state timeout pulse and a running stall-cycle counter.
//   clk, reset_n          : clock, async active-low reset
//   if_req / if_ack       : fetch outstanding / fetch data returned
//   mem_req / mem_ack     : MEM stage access / data bus completion
//   ex_branch_taken       : EX redirect
//   idex_memread, idex_rd_addr, id_rs1_addr, id_rs2_addr : load-use inputs
//   pc_stall, fs_ifid, fs_idex, fs_exmem, fs_memwb : controls (combinational)
//   bus_timeout           : one-cycle pulse after TIMEOUT_CYCLES wait cycles
//   stall_count           : cycles with pc_stall=1 (wraps)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        ex_branch_taken,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd_addr,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  output logic        pc_stall,
  output logic [1:0]  fs_ifid,
  output logic [1:0]  fs_idex,
  output logic [1:0]  fs_exmem,
  output logic [1:0]  fs_memwb,
  output logic        bus_timeout,
  output logic [31:0] stall_count
);

  if (ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("pipeline_ctrl: parameter out of range");
  end

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_state_nxt;
  logic        r_redirect, w_redirect_nxt;
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [31:0] r_stall_count;
  ctrl_t       w_ctrl;
  logic        w_mem_wait, w_if_wait, w_load_use, w_discard, w_timeout;

  load_use_detect u_lud (
    .i_idex_memread (idex_memread),
    .i_idex_rd_addr (idex_rd_addr),
    .i_id_rs1_addr  (id_rs1_addr),
    .i_id_rs2_addr  (id_rs2_addr),
    .o_hazard       (w_load_use)
  );

  assign w_mem_wait = mem_req && !mem_ack;
  assign w_if_wait  = if_req && !if_ack;
  // Fetch returning after a redirect was taken mid-wait carries the wrong-path
  // instruction; it must not land in IF/ID.
  assign w_discard  = (r_state == ST_IF_WAIT) && r_redirect && if_req && if_ack && !w_mem_wait;

  always_comb begin
    w_ctrl      = '{pc_stall: 1'b0, ifid: FS_NONE, idex: FS_NONE, exmem: FS_NONE, memwb: FS_NONE};
    w_state_nxt = r_state;
    if (w_mem_wait) begin
      w_ctrl      = '{pc_stall: 1'b1, ifid: FS_STALL, idex: FS_STALL, exmem: FS_STALL, memwb: FS_FLUSH};
      w_state_nxt = ST_MEM_WAIT;
    end else begin
      if (ex_branch_taken) begin
        w_ctrl.ifid = FS_FLUSH;
        w_ctrl.idex = FS_FLUSH;
      end else if (w_load_use) begin
        w_ctrl.pc_stall = 1'b1;
        w_ctrl.ifid     = FS_STALL;
        w_ctrl.idex     = FS_FLUSH;
      end else if (w_if_wait) begin
        w_ctrl.pc_stall = 1'b1;
        w_ctrl.ifid     = FS_FLUSH;
      end
      if (w_discard) w_ctrl.ifid = FS_FLUSH;
      // An outstanding fetch keeps IF_WAIT even while a higher-priority event
      // owns the outputs; from RUN a masked fetch wait is picked up next cycle.
      if (r_state == ST_IF_WAIT)
        w_state_nxt = w_if_wait ? ST_IF_WAIT : ST_RUN;
      else
        w_state_nxt = (w_if_wait && !ex_branch_taken && !w_load_use) ? ST_IF_WAIT : ST_RUN;
    end
    if (!reset_n)
      w_ctrl = '{pc_stall: 1'b1, ifid: FS_FLUSH, idex: FS_FLUSH, exmem: FS_FLUSH, memwb: FS_FLUSH};
  end

  // r_wait_cnt = wait cycles already completed in the current wait state, so
  // the pulse lands on the TIMEOUT_CYCLES-th wait cycle, counting the entry one.
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_state_nxt == ST_RUN)        w_wait_cnt_nxt = 16'd0;
    else if (w_state_nxt != r_state)  w_wait_cnt_nxt = 16'd1;
    else if (r_wait_cnt != 16'hFFFF)  w_wait_cnt_nxt = r_wait_cnt + 16'd1;
  end

  assign w_redirect_nxt = (r_state == ST_IF_WAIT) && (w_state_nxt == ST_IF_WAIT)
                          && (r_redirect || ex_branch_taken);
  assign w_timeout      = reset_n && (r_state != ST_RUN) && (w_state_nxt == r_state)
                          && (r_wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redirect    <= 1'b0;
      r_wait_cnt    <= 16'd0;
      r_stall_count <= 32'd0;
    end else begin
      r_redirect <= w_redirect_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_ctrl.pc_stall) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign pc_stall    = w_ctrl.pc_stall;
  assign fs_ifid     = w_ctrl.ifid;
  assign fs_idex     = w_ctrl.idex;
  assign fs_exmem    = w_ctrl.exmem;
  assign fs_memwb    = w_ctrl.memwb;
  assign bus_timeout = w_timeout;
  assign stall_count = r_stall_count;

endmodule
